// File: rtl/srm_datapath_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// srm_datapath_ctrl_pkg
// Shared constants and types for the Simple RISC Machine datapath controller:
// instruction widths, opcode/op encodings, controller state enum, ALU operation
// and regfile write-back source encodings, and the decoded-instruction record
// produced by the instruction decoder.
// ---------------------------------------------------------------------------
package srm_datapath_ctrl_pkg;

  localparam int DW     = 16;
  localparam int RSEL_W = 3;

  // Top-level instruction classes (ir[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-operation field (ir[12:11]) for the MOV class
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // Sub-operation field (ir[12:11]) for the ALU class
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // Regfile data_in source select
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_GET_A   = 3'd2,
    ST_GET_B   = 3'd3,
    ST_ALU     = 3'd4,
    ST_WR_IMM  = 3'd5,
    ST_WR_REG  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_t;

  // Everything the controller needs to know about the latched instruction
  typedef struct packed {
    logic [1:0]        op;
    logic [RSEL_W-1:0] rn;
    logic [RSEL_W-1:0] rd;
    logic [1:0]        sh;
    logic [RSEL_W-1:0] rm;
    logic [DW-1:0]     sximm8;
    logic              legal;
    logic              is_mov_imm;
    logic              is_mov_reg;
    logic              is_mvn;
    logic              is_cmp;
  } dec_t;

  function automatic logic [DW-1:0] sign_extend8(input logic [7:0] imm8);
    return {{(DW-8){imm8[7]}}, imm8};
  endfunction

endpackage

// File: rtl/srm_datapath_ctrl_if.sv
// ---------------------------------------------------------------------------
// srm_datapath_ctrl_if
// Bundles the instruction handshake and the datapath control bus of the SRM
// controller.
//   s, in        : start strobe and 16-bit instruction (source -> controller)
//   w            : controller idle and ready for s
//   readnum, writenum, write, loada, loadb, loadc, loads,
//   asel, bsel, vsel, alu_op, shift, sximm8 : datapath controls
//   illegal      : sticky flag, last instruction could not be decoded
// Modports:
//   slave  : the controller (consumes s/in, drives the control bus)
//   master : the instruction source / observer side
// ---------------------------------------------------------------------------
interface srm_datapath_ctrl_if;
  import srm_datapath_ctrl_pkg::*;

  logic              s;
  logic [DW-1:0]     in;
  logic              w;
  logic [RSEL_W-1:0] readnum;
  logic [RSEL_W-1:0] writenum;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        vsel;
  logic [1:0]        alu_op;
  logic [1:0]        shift;
  logic [DW-1:0]     sximm8;
  logic              illegal;

  modport slave (
    input  s, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, alu_op, shift, sximm8, illegal
  );

  modport master (
    output s, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, alu_op, shift, sximm8, illegal
  );

endinterface

// File: rtl/srm_datapath_ctrl_instr_dec.sv
// ---------------------------------------------------------------------------
// srm_datapath_ctrl_instr_dec
// Purely combinational split of the latched instruction register into its
// fields, sign extension of imm8, and classification flags.
// Ports:
//   ir  in  16  latched instruction
//   dec out     decoded record (fields, sximm8, legal and class flags)
// ---------------------------------------------------------------------------
module srm_datapath_ctrl_instr_dec
  import srm_datapath_ctrl_pkg::*;
(
  input  logic [DW-1:0] ir,
  output dec_t          dec
);

  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_mov_class;
  logic       is_alu_class;

  assign opcode       = ir[15:13];
  assign op           = ir[12:11];
  assign is_mov_class = (opcode == OPC_MOV);
  assign is_alu_class = (opcode == OPC_ALU);

  always_comb begin
    dec            = '0;
    dec.op         = op;
    dec.rn         = ir[10:8];
    dec.rd         = ir[7:5];
    dec.sh         = ir[4:3];
    dec.rm         = ir[2:0];
    dec.sximm8     = sign_extend8(ir[7:0]);
    dec.is_mov_imm = is_mov_class && (op == OP_MOV_IMM);
    dec.is_mov_reg = is_mov_class && (op == OP_MOV_REG);
    dec.is_mvn     = is_alu_class && (op == OP_MVN);
    dec.is_cmp     = is_alu_class && (op == OP_CMP);
    // Every op of the ALU class is defined; only two MOV sub-ops exist
    dec.legal      = is_alu_class || dec.is_mov_imm || dec.is_mov_reg;
  end

endmodule

// File: rtl/srm_datapath_ctrl.sv
// ---------------------------------------------------------------------------
// srm_datapath_ctrl
// Multi-cycle controller for the SRM 8x16 register file + ALU datapath.
// Latches one instruction when s is seen in WAIT, then steps through
// DECODE / GET_A / GET_B / ALU / WR_IMM / WR_REG driving Moore control
// outputs derived only from the state and the latched instruction.
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of srm_datapath_ctrl_if (s/in handshake, w,
//            regfile/pipeline/mux controls, shift, sximm8, illegal)
// ---------------------------------------------------------------------------
module srm_datapath_ctrl
  import srm_datapath_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  srm_datapath_ctrl_if.slave   bus
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] ir_q;
  logic          illegal_q;
  dec_t          dec;
  logic          one_src;
  logic          accept;

  logic              w_o;
  logic [RSEL_W-1:0] readnum_o;
  logic [RSEL_W-1:0] writenum_o;
  logic              write_o;
  logic              loada_o;
  logic              loadb_o;
  logic              loadc_o;
  logic              loads_o;
  logic              asel_o;
  logic [1:0]        vsel_o;
  logic [1:0]        alu_op_o;

  srm_datapath_ctrl_instr_dec u_dec (
    .ir  (ir_q),
    .dec (dec)
  );

  // MOV reg and MVN only need the B operand; A is forced to zero in the ALU
  assign one_src = dec.is_mov_reg || dec.is_mvn;
  assign accept  = (state_q == ST_WAIT) && bus.s;

  // State, instruction and sticky illegal flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_WAIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_q      <= bus.in;
        illegal_q <= 1'b0;
      end else if (state_q == ST_DECODE && !dec.legal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (bus.s) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!dec.legal)          state_d = ST_WAIT;
        else if (dec.is_mov_imm) state_d = ST_WR_IMM;
        else if (one_src)        state_d = ST_GET_B;
        else                     state_d = ST_GET_A;
      end
      ST_GET_A:  state_d = ST_GET_B;
      ST_GET_B:  state_d = ST_ALU;
      // CMP only updates status flags, so there is nothing to write back
      ST_ALU:    state_d = dec.is_cmp ? ST_WAIT : ST_WR_REG;
      ST_WR_IMM: state_d = ST_WAIT;
      ST_WR_REG: state_d = ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase
  end

  // Moore outputs; selects and alu_op rest at zero outside the states using them
  always_comb begin
    w_o        = 1'b0;
    readnum_o  = '0;
    writenum_o = '0;
    write_o    = 1'b0;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    asel_o     = 1'b0;
    vsel_o     = VSEL_C;
    alu_op_o   = ALU_ADD;
    case (state_q)
      ST_WAIT:  w_o = 1'b1;
      ST_GET_A: begin
        readnum_o = dec.rn;
        loada_o   = 1'b1;
      end
      ST_GET_B: begin
        readnum_o = dec.rm;
        loadb_o   = 1'b1;
      end
      ST_ALU: begin
        loadc_o  = 1'b1;
        asel_o   = one_src;
        // MOV reg passes the shifted B through as 0 + B
        alu_op_o = dec.is_mov_reg ? ALU_ADD : dec.op;
        loads_o  = dec.is_cmp;
      end
      ST_WR_IMM: begin
        writenum_o = dec.rn;
        vsel_o     = VSEL_IMM8;
        write_o    = 1'b1;
      end
      ST_WR_REG: begin
        writenum_o = dec.rd;
        vsel_o     = VSEL_C;
        write_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.w        = w_o;
  assign bus.readnum  = readnum_o;
  assign bus.writenum = writenum_o;
  assign bus.write    = write_o;
  assign bus.loada    = loada_o;
  assign bus.loadb    = loadb_o;
  assign bus.loadc    = loadc_o;
  assign bus.loads    = loads_o;
  assign bus.asel     = asel_o;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = vsel_o;
  assign bus.alu_op   = alu_op_o;
  assign bus.shift    = dec.sh;
  assign bus.sximm8   = dec.sximm8;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_srm_datapath_ctrl.sv
// ---------------------------------------------------------------------------
// tb_srm_datapath_ctrl
// Scoreboard bench for srm_datapath_ctrl. Each issued instruction pushes its
// hand-computed per-cycle control snapshots; a negedge monitor pops one entry
// for every busy (w=0) cycle and compares the whole control bus.
// ---------------------------------------------------------------------------
module tb_srm_datapath_ctrl;
  import srm_datapath_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic        illegal;
  } snap_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  srm_datapath_ctrl_if bus();

  srm_datapath_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  snap_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    busy_idx = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic snap_t mk(input logic [2:0] rnum, input logic [2:0] wnum,
                               input logic wr, input logic la, input logic lb,
                               input logic lc, input logic ls, input logic as,
                               input logic [1:0] vs, input logic [1:0] aop,
                               input logic [1:0] sh, input logic [15:0] imm);
    snap_t r;
    r.readnum  = rnum;
    r.writenum = wnum;
    r.write    = wr;
    r.loada    = la;
    r.loadb    = lb;
    r.loadc    = lc;
    r.loads    = ls;
    r.asel     = as;
    r.bsel     = 1'b0;
    r.vsel     = vs;
    r.alu_op   = aop;
    r.shift    = sh;
    r.sximm8   = imm;
    r.illegal  = 1'b0;
    return r;
  endfunction

  function automatic snap_t sample();
    snap_t r;
    r.readnum  = bus.readnum;
    r.writenum = bus.writenum;
    r.write    = bus.write;
    r.loada    = bus.loada;
    r.loadb    = bus.loadb;
    r.loadc    = bus.loadc;
    r.loads    = bus.loads;
    r.asel     = bus.asel;
    r.bsel     = bus.bsel;
    r.vsel     = bus.vsel;
    r.alu_op   = bus.alu_op;
    r.shift    = bus.shift;
    r.sximm8   = bus.sximm8;
    r.illegal  = bus.illegal;
    return r;
  endfunction

  // Monitor: every busy cycle must match the next expected snapshot
  always @(negedge clk) begin
    snap_t e;
    if (reset_n && bus.w === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL busy_cycle_%0d: got unexpected busy cycle expected w=1", busy_idx);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("busy_cycle_%0d", busy_idx), 64'(sample()), 64'(e));
      end
      busy_idx++;
    end
  end

  // ADD R2,R1,R0 (0xA148): sh=01, sximm8=0x0048
  task automatic pushAdd();
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0048));
    exp_q.push_back(mk(3'd1, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0048));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0048));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0048));
    exp_q.push_back(mk(3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0048));
  endtask

  // MOV R0,#-2 (0xD0FE): sh=11, sximm8=0xFFFE
  task automatic pushMovImm();
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 16'hFFFE));
    exp_q.push_back(mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b11, 16'hFFFE));
  endtask

  // Issue one instruction with a single-cycle s, optionally pulse s again
  // pulse_at cycles after acceptance, then measure accept-to-idle latency.
  task automatic applyStimulus(input logic [15:0] instr, input int latency,
                               input int pulse_at, input string name);
    int cycles;
    @(negedge clk);
    bus.s  = 1'b1;
    bus.in = instr;
    @(posedge clk);
    #1;
    bus.s  = 1'b0;
    bus.in = 16'hFFFF;
    cycles = 0;
    while (bus.w !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == pulse_at) begin
        bus.s  = 1'b1;
        bus.in = 16'hD5FF;
      end else begin
        bus.s  = 1'b0;
      end
    end
    bus.s = 1'b0;
    checkOutput({name, "_latency"}, 64'(cycles + 1), 64'(latency));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s  = 1'b0;
    bus.in = 16'h0000;

    // Reset state
    #1;
    checkOutput("reset_w", 64'(bus.w), 64'd1);
    checkOutput("reset_write", 64'(bus.write), 64'd0);
    checkOutput("reset_illegal", 64'(bus.illegal), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted while ADD sits in ALU: nothing may be written back
    pushAdd();
    @(negedge clk);
    bus.s  = 1'b1;
    bus.in = 16'hA148;
    @(posedge clk);
    #1;
    bus.s  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midop_in_alu_loadc", 64'(bus.loadc), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midop_reset_w", 64'(bus.w), 64'd1);
    checkOutput("midop_reset_write", 64'(bus.write), 64'd0);
    checkOutput("midop_reset_loadc", 64'(bus.loadc), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("midop_held_write", 64'(bus.write), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // MOV R0,#-2
    pushMovImm();
    applyStimulus(16'hD0FE, 3, 0, "mov_imm");

    // ADD R2,R1,R0
    pushAdd();
    applyStimulus(16'hA148, 6, 0, "add");

    // CMP R1,R0: flags only, no write cycle
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
    exp_q.push_back(mk(3'd1, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 16'h0000));
    applyStimulus(16'hA900, 5, 0, "cmp");

    // MOV R3,R1,LSL#1
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0069));
    exp_q.push_back(mk(3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0069));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b01, 16'h0069));
    exp_q.push_back(mk(3'd0, 3'd3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 16'h0069));
    applyStimulus(16'hC069, 5, 0, "mov_reg");

    // MVN R4,R1
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFF81));
    exp_q.push_back(mk(3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFF81));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b11, 2'b00, 16'hFF81));
    exp_q.push_back(mk(3'd0, 3'd4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFF81));
    applyStimulus(16'hB881, 5, 0, "mvn");

    // AND R5,R2,R7 (0xB2A7)
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA7));
    exp_q.push_back(mk(3'd2, 3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA7));
    exp_q.push_back(mk(3'd7, 3'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA7));
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 16'hFFA7));
    exp_q.push_back(mk(3'd0, 3'd5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFA7));
    applyStimulus(16'hB2A7, 6, 0, "and");

    // Illegal opcode 111
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
    applyStimulus(16'hE000, 2, 0, "illegal_e000");
    checkOutput("illegal_set", 64'(bus.illegal), 64'd1);

    // Valid ADD with a stray s pulse during GET_A; illegal must clear
    pushAdd();
    applyStimulus(16'hA148, 6, 1, "add_midpulse");
    checkOutput("illegal_cleared", 64'(bus.illegal), 64'd0);

    // MOV class with undefined op 01
    exp_q.push_back(mk(3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
    applyStimulus(16'hC800, 2, 0, "illegal_c800");
    checkOutput("illegal_set_c800", 64'(bus.illegal), 64'd1);

    // s held high across two MOV imm: w high for exactly one cycle between
    pushMovImm();
    pushMovImm();
    @(negedge clk);
    bus.s  = 1'b1;
    bus.in = 16'hD0FE;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("held_s_w_high", 64'(bus.w), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("held_s_reaccept", 64'(bus.w), 64'd0);
    bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_s_done", 64'(bus.w), 64'd1);

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
